// File: rtl/ccip_rsp_pkg.sv
// rtl/ccip_rsp_pkg.sv - CCI-P channel types, latency pipeline entries and address range helper
package ccip_rsp_pkg;

   typedef logic [41:0]  t_ccip_clAddr;
   typedef logic [15:0]  t_ccip_mdata;
   typedef logic [511:0] t_ccip_clData;

   typedef enum logic [1:0] {eCL_LEN_1 = 2'b00, eCL_LEN_2 = 2'b01, eCL_LEN_4 = 2'b11} t_ccip_clLen;
   typedef enum logic [1:0] {eVC_VA = 2'b00, eVC_VL0 = 2'b01, eVC_VH0 = 2'b10, eVC_VH1 = 2'b11} t_ccip_vc;
   typedef enum logic [3:0] {eREQ_RDLINE_I = 4'h0, eREQ_RDLINE_S = 4'h1} t_ccip_c0_req;
   typedef enum logic [3:0] {eREQ_WRLINE_I = 4'h0, eREQ_WRLINE_M = 4'h1, eREQ_WRFENCE = 4'h4} t_ccip_c1_req;
   typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4} t_ccip_c0_rsp;
   typedef enum logic [3:0] {eRSP_WRLINE = 4'h0, eRSP_WRFENCE = 4'h4} t_ccip_c1_rsp;

   typedef struct packed {
      t_ccip_vc     vc_sel;
      logic [1:0]   rsvd1;
      t_ccip_clLen  cl_len;
      t_ccip_c0_req req_type;
      logic [5:0]   rsvd0;
      t_ccip_clAddr address;
      t_ccip_mdata  mdata;
   } t_ccip_c0_ReqMemHdr;

   typedef struct packed {
      logic [5:0]   rsvd2;
      t_ccip_vc     vc_sel;
      logic         sop;
      logic         rsvd1;
      t_ccip_clLen  cl_len;
      t_ccip_c1_req req_type;
      logic [5:0]   rsvd0;
      t_ccip_clAddr address;
      t_ccip_mdata  mdata;
   } t_ccip_c1_ReqMemHdr;

   typedef struct packed { t_ccip_c0_ReqMemHdr hdr; logic valid; } t_if_ccip_c0_Tx;
   typedef struct packed { t_ccip_c1_ReqMemHdr hdr; t_ccip_clData data; logic valid; } t_if_ccip_c1_Tx;
   typedef struct packed { logic [8:0] tid; logic [63:0] data; logic mmioRdValid; } t_if_ccip_c2_Tx;
   typedef struct packed { t_if_ccip_c0_Tx c0; t_if_ccip_c1_Tx c1; t_if_ccip_c2_Tx c2; } t_if_ccip_Tx;

   typedef struct packed {
      t_ccip_vc     vc_used;
      logic         rsvd1;
      logic         hit_miss;
      logic [1:0]   rsvd0;
      logic [1:0]   cl_num;
      t_ccip_c0_rsp resp_type;
      t_ccip_mdata  mdata;
   } t_ccip_c0_RspMemHdr;

   typedef struct packed {
      t_ccip_vc     vc_used;
      logic         rsvd1;
      logic         hit_miss;
      logic         format;
      logic         rsvd0;
      logic [1:0]   cl_num;
      t_ccip_c1_rsp resp_type;
      t_ccip_mdata  mdata;
   } t_ccip_c1_RspMemHdr;

   typedef struct packed {
      t_ccip_c0_RspMemHdr hdr;
      t_ccip_clData       data;
      logic               rspValid;
      logic               mmioRdValid;
      logic               mmioWrValid;
   } t_if_ccip_c0_Rx;

   typedef struct packed { t_ccip_c1_RspMemHdr hdr; logic rspValid; } t_if_ccip_c1_Rx;

   typedef struct packed {
      logic           c0TxAlmFull;
      logic           c1TxAlmFull;
      t_if_ccip_c0_Rx c0;
      t_if_ccip_c1_Rx c1;
   } t_if_ccip_Rx;

   typedef struct packed { logic valid; t_ccip_mdata mdata; t_ccip_clData data; } t_rd_pipe_entry;
   typedef struct packed { logic valid; t_ccip_mdata mdata; } t_wr_pipe_entry;

   localparam int unsigned RD_LATENCY_MIN = 2;
   localparam int unsigned WR_LATENCY_MIN = 2;

   // Unsigned 42-bit distance from the window base; addresses below base wrap high and fall out.
   function automatic logic cl_in_range(t_ccip_clAddr addr, t_ccip_clAddr base, int unsigned depth);
      t_ccip_clAddr off;
      off = addr - base;
      return off < t_ccip_clAddr'(depth);
   endfunction

endpackage

// File: rtl/ccip_host_mem_responder_if.sv
// rtl/ccip_host_mem_responder_if.sv - CCI-P AFU<->host channel bundle with AFU (master) and host (slave) views
interface ccip_host_mem_responder_if;
   import ccip_rsp_pkg::*;

   t_if_ccip_Tx af2cp_sTx;
   t_if_ccip_Rx cp2af_sRx;

   modport master (output af2cp_sTx, input cp2af_sRx);
   modport slave  (input af2cp_sTx, output cp2af_sRx);
endinterface

// File: rtl/ccip_rsp_delay_line.sv
// rtl/ccip_rsp_delay_line.sv - fixed-latency valid/payload shift pipeline; only the valid bits are reset
module ccip_rsp_delay_line #(
   parameter int unsigned LATENCY = 1,
   parameter int unsigned WIDTH   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   logic [LATENCY-1:0] vld;
   logic [WIDTH-1:0]   pay [LATENCY];

   always_ff @(posedge clk) begin
      if (reset) begin
         vld <= '0;
      end else begin
         vld[0] <= in_valid;
         for (int i = 1; i < int'(LATENCY); i++) vld[i] <= vld[i-1];
      end
   end

   always_ff @(posedge clk) begin
      pay[0] <= in_data;
      for (int i = 1; i < int'(LATENCY); i++) pay[i] <= pay[i-1];
   end

   assign out_valid = vld[LATENCY-1];
   assign out_data  = pay[LATENCY-1];

endmodule

// File: rtl/ccip_host_mem_responder.sv
// rtl/ccip_host_mem_responder.sv - CCI-P host memory responder serving RDLINE/WRLINE from a cache-line window
// Optional almost-full injection and violation counter: CCIP_RSP_ALMFULL_INJECT_EN
module ccip_host_mem_responder
   import ccip_rsp_pkg::*;
#(
   parameter int unsigned  DEPTH          = 256,
   parameter t_ccip_clAddr BASE_CL        = 42'h0,
   parameter int unsigned  READ_LATENCY   = 8,
   parameter int unsigned  WRITE_LATENCY  = 4,
   parameter int unsigned  ALMFULL_PERIOD = 16,
   localparam int          IDX_W          = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                reset,
   ccip_host_mem_responder_if.slave ccip,
   input  logic                host_wr_en,
   input  logic [IDX_W-1:0]    host_wr_idx,
   input  logic [511:0]        host_wr_data,
   input  logic [IDX_W-1:0]    host_rd_idx,
   output logic [511:0]        host_rd_data,
   output logic [31:0]         reads_served,
   output logic [31:0]         writes_served,
`ifdef CCIP_RSP_ALMFULL_INJECT_EN
   output logic [15:0]         almfull_violations,
`endif
   output logic [15:0]         err_count
);

   localparam int unsigned RD_LAT = (READ_LATENCY  > RD_LATENCY_MIN) ? READ_LATENCY  : RD_LATENCY_MIN;
   localparam int unsigned WR_LAT = (WRITE_LATENCY > WR_LATENCY_MIN) ? WRITE_LATENCY : WR_LATENCY_MIN;

   t_if_ccip_Tx    tx;
   t_if_ccip_Rx    rx;
   t_ccip_clData   mem [DEPTH];
   t_rd_pipe_entry rd_s1, rd_out;
   t_wr_pipe_entry wr_in, wr_out;
   logic           rd_in_range, wr_in_range, wr_do, rd_err, wr_err, almfull;
   logic [IDX_W-1:0] rd_idx, wr_idx;
   logic [16:0]    err_sum;
   logic           unused_tx;

   assign tx        = ccip.af2cp_sTx;
   assign unused_tx = ^tx;

   assign rd_in_range = cl_in_range(tx.c0.hdr.address, BASE_CL, DEPTH);
   assign wr_in_range = cl_in_range(tx.c1.hdr.address, BASE_CL, DEPTH);
   assign rd_idx      = IDX_W'(tx.c0.hdr.address - BASE_CL);
   assign wr_idx      = IDX_W'(tx.c1.hdr.address - BASE_CL);
   assign wr_do       = tx.c1.valid && tx.c1.hdr.sop && wr_in_range;
   assign rd_err      = tx.c0.valid && (!rd_in_range || tx.c0.hdr.cl_len != eCL_LEN_1);
   assign wr_err      = tx.c1.valid && (!tx.c1.hdr.sop || !wr_in_range || tx.c1.hdr.cl_len != eCL_LEN_1);
   assign err_sum     = {1'b0, err_count} + {16'd0, rd_err} + {16'd0, wr_err};

   // Host port is written first so a colliding AFU write to the same line lands last.
   always_ff @(posedge clk) begin
      if (host_wr_en) mem[host_wr_idx] <= host_wr_data;
      if (wr_do && !reset) mem[wr_idx] <= tx.c1.data;
   end

   // Reads sample the array before this edge's writes commit, so same-cycle writes are not seen.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_s1.valid  <= 1'b0;
         host_rd_data <= '0;
      end else begin
         rd_s1.valid  <= tx.c0.valid;
         host_rd_data <= mem[host_rd_idx];
      end
      rd_s1.mdata <= tx.c0.hdr.mdata;
      rd_s1.data  <= rd_in_range ? mem[rd_idx] : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         reads_served  <= '0;
         writes_served <= '0;
         err_count     <= '0;
      end else begin
         reads_served  <= reads_served + {31'd0, tx.c0.valid && rd_in_range};
         writes_served <= writes_served + {31'd0, wr_do};
         err_count     <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      end
   end

   ccip_rsp_delay_line #(.LATENCY(RD_LAT - 1), .WIDTH(16 + 512)) u_rd_line (
      .clk      (clk),
      .reset    (reset),
      .in_valid (rd_s1.valid),
      .in_data  ({rd_s1.mdata, rd_s1.data}),
      .out_valid(rd_out.valid),
      .out_data ({rd_out.mdata, rd_out.data})
   );

   assign wr_in.valid = tx.c1.valid && tx.c1.hdr.sop;
   assign wr_in.mdata = tx.c1.hdr.mdata;

   ccip_rsp_delay_line #(.LATENCY(WR_LAT), .WIDTH(16)) u_wr_line (
      .clk      (clk),
      .reset    (reset),
      .in_valid (wr_in.valid),
      .in_data  (wr_in.mdata),
      .out_valid(wr_out.valid),
      .out_data (wr_out.mdata)
   );

`ifdef CCIP_RSP_ALMFULL_INJECT_EN
   logic [15:0] af_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         af_cnt             <= '0;
         almfull_violations <= '0;
      end else begin
         af_cnt <= (af_cnt == 16'(ALMFULL_PERIOD - 1)) ? '0 : af_cnt + 16'd1;
         if (almfull)
            almfull_violations <= almfull_violations + 16'(tx.c0.valid) + 16'(tx.c1.valid);
      end
   end

   assign almfull = af_cnt >= 16'(ALMFULL_PERIOD - 4);
`else
   logic unused_almfull_period;
   assign unused_almfull_period = (ALMFULL_PERIOD == 0);
   assign almfull = 1'b0;
`endif

   always_comb begin
      rx                  = '0;
      rx.c0TxAlmFull      = almfull;
      rx.c1TxAlmFull      = almfull;
      rx.c0.rspValid      = rd_out.valid;
      rx.c0.hdr.resp_type = eRSP_RDLINE;
      rx.c0.hdr.mdata     = rd_out.mdata;
      rx.c0.data          = rd_out.data;
      rx.c1.rspValid      = wr_out.valid;
      rx.c1.hdr.resp_type = eRSP_WRLINE;
      rx.c1.hdr.mdata     = wr_out.mdata;
   end

   assign ccip.cp2af_sRx = rx;

endmodule

// File: tb/tb_ccip_host_mem_responder.sv
// tb/tb_ccip_host_mem_responder.sv - directed plus random bench for ccip_host_mem_responder against a line-array model
module tb_ccip_host_mem_responder;
   import ccip_rsp_pkg::*;

   localparam int unsigned  DEPTH = 256;
   localparam int           IW    = 8;
   localparam t_ccip_clAddr BASE  = 42'h1000;
   localparam int           RL    = 8;
   localparam int           WL    = 4;
   localparam int           AP    = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic          host_wr_en = 1'b0;
   logic [IW-1:0] host_wr_idx = '0;
   logic [511:0]  host_wr_data = '0;
   logic [IW-1:0] host_rd_idx = '0;
   logic [511:0]  host_rd_data;
   logic [31:0]   reads_served, writes_served;
   logic [15:0]   err_count;
`ifdef CCIP_RSP_ALMFULL_INJECT_EN
   logic [15:0]   viol_obs;
`endif

   always #5 clk = ~clk;

   ccip_host_mem_responder_if bus();

   ccip_host_mem_responder #(
      .DEPTH(DEPTH), .BASE_CL(BASE), .READ_LATENCY(RL), .WRITE_LATENCY(WL), .ALMFULL_PERIOD(AP)
   ) dut (
      .clk(clk), .reset(reset), .ccip(bus),
      .host_wr_en(host_wr_en), .host_wr_idx(host_wr_idx), .host_wr_data(host_wr_data),
      .host_rd_idx(host_rd_idx), .host_rd_data(host_rd_data),
      .reads_served(reads_served), .writes_served(writes_served),
`ifdef CCIP_RSP_ALMFULL_INJECT_EN
      .almfull_violations(viol_obs),
`endif
      .err_count(err_count)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // Reference model: line array, per-cycle response schedule, counters.
   logic [511:0] mem_m [DEPTH];
   bit           exp_rv [int];
   logic [15:0]  exp_rm [int];
   logic [511:0] exp_rd [int];
   bit           exp_wv [int];
   logic [15:0]  exp_wm [int];
   logic [31:0]  reads_m = 0, writes_m = 0;
   int           err_m = 0;
   logic [511:0] hr_exp = '0;
   int           af_m = 0;
   logic [15:0]  viol_m = 0;

   bit           q_rd = 0, q_wr = 0, q_hw = 0, q_rst = 0;
   t_ccip_clAddr q_ra = '0, q_wa = '0;
   logic [15:0]  q_rm = '0, q_wm = '0;
   t_ccip_clLen  q_rl = eCL_LEN_1;
   logic [511:0] q_wd = '0, q_hwd = '0;
   logic [IW-1:0] q_hwi = '0, q_hri = '0;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check();
      bit ev;
      ev = exp_rv.exists(cyc);
      chk("c0_rsp_valid", 512'(bus.cp2af_sRx.c0.rspValid), 512'(ev));
      if (ev) begin
         chk("c0_mdata", 512'(bus.cp2af_sRx.c0.hdr.mdata), 512'(exp_rm[cyc]));
         chk("c0_data", bus.cp2af_sRx.c0.data, exp_rd[cyc]);
         chk("c0_resp_type", 512'(bus.cp2af_sRx.c0.hdr.resp_type), 512'(eRSP_RDLINE));
         chk("c0_cl_num", 512'(bus.cp2af_sRx.c0.hdr.cl_num), 512'(0));
         exp_rv.delete(cyc);
      end
      chk("c0_mmio_valid", 512'({bus.cp2af_sRx.c0.mmioRdValid, bus.cp2af_sRx.c0.mmioWrValid}), 512'(0));
      ev = exp_wv.exists(cyc);
      chk("c1_rsp_valid", 512'(bus.cp2af_sRx.c1.rspValid), 512'(ev));
      if (ev) begin
         chk("c1_mdata", 512'(bus.cp2af_sRx.c1.hdr.mdata), 512'(exp_wm[cyc]));
         chk("c1_resp_type", 512'(bus.cp2af_sRx.c1.hdr.resp_type), 512'(eRSP_WRLINE));
         chk("c1_format", 512'(bus.cp2af_sRx.c1.hdr.format), 512'(0));
         exp_wv.delete(cyc);
      end
      chk("reads_served", 512'(reads_served), 512'(reads_m));
      chk("writes_served", 512'(writes_served), 512'(writes_m));
      chk("err_count", 512'(err_count), 512'(err_m));
      chk("host_rd_data", host_rd_data, hr_exp);
`ifdef CCIP_RSP_ALMFULL_INJECT_EN
      chk("almfull", 512'({bus.cp2af_sRx.c0TxAlmFull, bus.cp2af_sRx.c1TxAlmFull}),
          512'((af_m % AP) >= AP - 4 ? 2'b11 : 2'b00));
      chk("almfull_violations", 512'(viol_obs), 512'(viol_m));
`else
      chk("almfull", 512'({bus.cp2af_sRx.c0TxAlmFull, bus.cp2af_sRx.c1TxAlmFull}), 512'(0));
`endif
   endtask

   task automatic step();
      t_ccip_clAddr roff, woff;
      bit rin, win;
      int inc;
      bus.af2cp_sTx = '0;
      bus.af2cp_sTx.c0.valid         = q_rd;
      bus.af2cp_sTx.c0.hdr.address   = q_ra;
      bus.af2cp_sTx.c0.hdr.mdata     = q_rm;
      bus.af2cp_sTx.c0.hdr.cl_len    = q_rl;
      bus.af2cp_sTx.c0.hdr.req_type  = eREQ_RDLINE_S;
      bus.af2cp_sTx.c1.valid         = q_wr;
      bus.af2cp_sTx.c1.hdr.sop       = 1'b1;
      bus.af2cp_sTx.c1.hdr.address   = q_wa;
      bus.af2cp_sTx.c1.hdr.mdata     = q_wm;
      bus.af2cp_sTx.c1.hdr.cl_len    = eCL_LEN_1;
      bus.af2cp_sTx.c1.hdr.req_type  = eREQ_WRLINE_I;
      bus.af2cp_sTx.c1.data          = q_wd;
      host_wr_en   = q_hw;
      host_wr_idx  = q_hwi;
      host_wr_data = q_hwd;
      host_rd_idx  = q_hri;
      reset        = q_rst;
      roff = q_ra - BASE;
      woff = q_wa - BASE;
      rin  = roff < t_ccip_clAddr'(DEPTH);
      win  = woff < t_ccip_clAddr'(DEPTH);
      if (q_rst) begin
         exp_rv.delete(); exp_rm.delete(); exp_rd.delete(); exp_wv.delete(); exp_wm.delete();
         reads_m = 0; writes_m = 0; err_m = 0; hr_exp = '0; viol_m = 0;
      end else begin
         inc = 0;
         if (q_rd) begin
            exp_rv[cyc+RL] = 1'b1;
            exp_rm[cyc+RL] = q_rm;
            exp_rd[cyc+RL] = rin ? mem_m[roff[IW-1:0]] : '0;
            if (rin) reads_m = reads_m + 1;
            if (!rin || q_rl != eCL_LEN_1) inc++;
         end
         if (q_wr) begin
            exp_wv[cyc+WL] = 1'b1;
            exp_wm[cyc+WL] = q_wm;
            if (win) writes_m = writes_m + 1;
            else inc++;
         end
         err_m = (err_m + inc > 65535) ? 65535 : err_m + inc;
         if ((af_m % AP) >= AP - 4) viol_m = viol_m + 16'(q_rd) + 16'(q_wr);
         hr_exp = mem_m[q_hri];
         if (q_hw) mem_m[q_hwi] = q_hwd;
         if (q_wr && win) mem_m[woff[IW-1:0]] = q_wd;
      end
      @(posedge clk);
      cyc++;
      af_m = q_rst ? 0 : (af_m + 1) % AP;
      #1;
      check();
      q_rd = 0; q_wr = 0; q_hw = 0; q_rst = 0; q_rl = eCL_LEN_1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   function automatic t_ccip_clAddr rand_addr();
      int pick;
      pick = int'($urandom_range(0, 19));
      if (pick < 16) return BASE + t_ccip_clAddr'(pick);
      if (pick < 18) return BASE - t_ccip_clAddr'(pick - 15);
      return BASE + t_ccip_clAddr'(DEPTH) + t_ccip_clAddr'(pick - 18);
   endfunction

   initial begin
      bus.af2cp_sTx = '0;
      q_rst = 1; step(); q_rst = 1; step(); q_rst = 1; step();

      for (int i = 0; i < 16; i++) begin
         q_hw = 1; q_hwi = IW'(i);
         q_hwd = (i < 4) ? 512'(32'hA0 + i) : {16{$urandom}};
         step();
      end

      for (int i = 0; i < 4; i++) begin
         q_rd = 1; q_ra = BASE + t_ccip_clAddr'(i); q_rm = 16'(i); step();
      end
      idle(10);

      q_wr = 1; q_wa = BASE + 42'd5; q_wm = 16'd7; q_wd = 512'hFF; step();
      q_hri = 8'd5; idle(6);

      q_rd = 1; q_ra = BASE + 42'd2; q_rm = 16'd9;
      q_wr = 1; q_wa = BASE + 42'd2; q_wm = 16'd8; q_wd = 512'h55; step();
      q_rd = 1; q_ra = BASE + 42'd2; q_rm = 16'd10; step();
      idle(9);

      q_hri = 8'd0;
      q_rd = 1; q_ra = 42'h0FFF; q_rm = 16'd11;
      q_wr = 1; q_wa = 42'h1100; q_wm = 16'd12; q_wd = 512'hDEAD; step();
      idle(9);

      q_rd = 1; q_ra = BASE + 42'd1; q_rm = 16'd13; q_rl = eCL_LEN_2; step();
      q_hw = 1; q_hwi = 8'd6; q_hwd = 512'h1111;
      q_wr = 1; q_wa = BASE + 42'd6; q_wm = 16'd14; q_wd = 512'h2222; step();
      q_hri = 8'd6;
      q_hw = 1; q_hwi = 8'd7; q_hwd = 512'h3333;
      q_rd = 1; q_ra = BASE + 42'd7; q_rm = 16'd15; step();
      q_hri = 8'd7; idle(10);

      for (int n = 0; n < 400; n++) begin
         q_rd = $urandom_range(0, 1) == 1; q_ra = rand_addr(); q_rm = 16'($urandom);
         q_rl = ($urandom_range(0, 7) == 0) ? eCL_LEN_2 : eCL_LEN_1;
         q_wr = $urandom_range(0, 1) == 1; q_wa = rand_addr(); q_wm = 16'($urandom);
         q_wd = {16{$urandom}};
         q_hw = $urandom_range(0, 3) == 0; q_hwi = IW'($urandom_range(0, 15)); q_hwd = {16{$urandom}};
         q_hri = IW'($urandom_range(0, 15));
         step();
      end
      idle(10);

      for (int i = 0; i < 2; i++) begin
         q_rd = 1; q_ra = BASE + t_ccip_clAddr'(i); q_rm = 16'(20 + i); step();
      end
      q_rd = 1; q_ra = BASE + 42'd2; q_rm = 16'd22; q_rst = 1; step();
      idle(12);

`ifdef CCIP_RSP_ALMFULL_INJECT_EN
      for (int i = 0; i < AP && af_m != 13; i++) step();
      q_rd = 1; q_ra = BASE; q_rm = 16'd30; step();
      idle(10);
`endif

      for (int n = 0; n < 32770; n++) begin
         q_rd = 1; q_ra = 42'h0FFF; q_rm = 16'(n);
         q_wr = 1; q_wa = BASE + t_ccip_clAddr'(DEPTH); q_wm = 16'(n);
         step();
      end
      idle(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ccip_host_mem_responder.md
Name: ccip_host_mem_responder

Overview:
- Host-side responder for the CCI-P interface: the other end of the scan AFU's read/write traffic.
- Accepts c0 RDLINE read requests and c1 WRLINE write requests from an AFU.
- Serves both from an on-chip cache-line memory window.
- Returns ordered read responses and write acks after fixed latencies.
- Used in standalone AFU benches and FPGA loopback builds; a host-side port preloads partitions and reads back result bitmaps.

Parameters:
- DEPTH, 256, cache lines in the memory window (power of two).
- BASE_CL, 42'h0, cache-line address that maps to index 0.
- READ_LATENCY, 8, cycles from request acceptance to c0 response valid (≥2).
- WRITE_LATENCY, 4, cycles from write acceptance to c1 write response valid (≥2).
- ALMFULL_PERIOD, 16, injection period, used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- af2cp_sTx  in  t_if_ccip_Tx  AFU requests; c0 and c1 used, c2 ignored
- cp2af_sRx  out  t_if_ccip_Rx  responses and almost-full flags to the AFU
- host_wr_en  in  1  host preload strobe
- host_wr_idx  in  $clog2(DEPTH)  preload line index
- host_wr_data  in  512  preload data
- host_rd_idx  in  $clog2(DEPTH)  inspect index
- host_rd_data  out  512  registered line at host_rd_idx, 1-cycle latency
- reads_served  out  32  accepted in-range reads
- writes_served  out  32  accepted in-range writes
- err_count  out  16  out-of-range or unsupported requests; saturates at 16'hFFFF

Behaviour:
- Reset values:
  - All cp2af_sRx valid bits = 0; c0TxAlmFull = c1TxAlmFull = 0.
  - Counters = 0; host_rd_data = 0; both latency pipelines flushed.
  - Memory contents are not cleared.
- Index computation: idx = addr - BASE_CL, computed in 42-bit arithmetic.
  - In range when the unsigned result is < DEPTH; otherwise out-of-range (OOR).
- Read (af2cp_sTx.c0.valid):
  - Accepted every cycle; no backpressure.
  - Data is sampled from memory in the acceptance cycle. A same-cycle write to the same line is not visible; the read returns old data.
  - Response after exactly READ_LATENCY cycles: c0.rspValid=1, hdr.resp_type=eRSP_RDLINE, hdr.mdata echoed, hdr.cl_num=0.
  - Responses leave in acceptance order, up to one per cycle.
- Write (af2cp_sTx.c1.valid with sop=1):
  - Memory is updated on the acceptance clock edge.
  - Ack after exactly WRITE_LATENCY cycles: c1.rspValid=1, resp_type=eRSP_WRLINE, mdata echoed, format=0.
- Unsupported or OOR requests:
  - cl_len != eCL_LEN_1: treated as a single line; err_count increments.
  - OOR read: returns 512'h0 with a normal response; err_count increments.
  - OOR write: memory untouched but still acked; err_count increments.
  - Reads and writes in the same cycle each increment err_count once, so a cycle can add 2.
- Concurrency:
  - c0 and c1 responses may be valid in the same cycle.
  - Host write and AFU write to the same index in the same cycle: the AFU write wins.
  - Host write and AFU read in the same cycle: the read sees old data.
- Counters:
  - reads_served and writes_served increment only for in-range requests.
  - 32-bit wrap is allowed.
- Reset mid-operation: in-flight responses are discarded, and no response is emitted after reset deasserts.
- c2 (MMIO) and any c0 MMIO fields are never driven valid.

Optional Feature:
- Macro: CCIP_RSP_ALMFULL_INJECT_EN.
- Defined:
  - A free-running counter mod ALMFULL_PERIOD drives c0TxAlmFull and c1TxAlmFull high for the last 4 counts of each period.
  - Requests arriving while almost-full is high are still served, and a 16-bit almfull_violations output counts them.
- Undefined: both flags are tied 0 and the almfull_violations port is absent.

Decomposition:
- Package ccip_rsp_pkg holds:
  - t_rd_pipe_entry {valid, mdata, data[511:0]} and t_wr_pipe_entry {valid, mdata};
  - latency-minimum localparams;
  - an index-range helper function.
- One natural sub-module: ccip_rsp_delay_line, a parameterized fixed-latency valid/payload shift pipeline, instantiated once per channel.

Test Plan:
- Preload idx 0..3 with 512'hA0..A3, BASE_CL=42'h1000; AFU reads 42'h1000..42'h1003 back-to-back with mdata 0..3 → four c0 responses on cycles t+8..t+11 carrying A0..A3 and mdata 0..3 in order; reads_served=4.
- AFU writes 512'hFF to 42'h1005 with mdata=7 → c1 ack at t+4 with mdata=7; host_rd_idx=5 returns 512'hFF one cycle later; writes_served=1.
- Same-cycle read and write to 42'h1002 (old A2, new 512'h55) → read returns A2; a following read returns 512'h55.
- Read 42'h0FFF and write 42'h1100 (DEPTH=256) → read returns 0, write acked, memory unchanged, err_count=2.
- Issue 3 reads, assert reset at t+2 for one cycle → no c0 response after reset; all counters 0.
- With CCIP_RSP_ALMFULL_INJECT_EN and ALMFULL_PERIOD=16 → c0TxAlmFull high on counts 12..15; one read issued at count 13 is served and almfull_violations=1.
